// File: rtl/tqvp_gera_gray_pkg.sv
// tqvp_gera_gray_pkg: register map, FSM encoding, status bits and Gray decoding shared by the Gray reader.
package tqvp_gera_gray_pkg;
    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_POS    = 4'h1;
    localparam logic [3:0] ADDR_RAW    = 4'h2;
    localparam logic [3:0] ADDR_REV    = 4'h3;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_ERRCNT = 4'h5;
    localparam int CTRL_EN    = 0;
    localparam int CTRL_INV   = 1;
    localparam int CTRL_CLR   = 7;
    localparam int STAT_VALID = 0;
    localparam int STAT_CHG   = 1;
    localparam int STAT_ERR   = 2;
    localparam int STAT_DIR   = 3;
    typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_TRACK} state_e;
    // Bits above w are masked off, so each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [7:0] gray2bin(input logic [7:0] g, input int w);
        logic [7:0] b;
        b = g & ((8'd1 << w) - 8'd1);
        for (int i = 6; i >= 0; i--) b[i] = b[i] ^ b[i + 1];
        return b;
    endfunction
endpackage

// File: rtl/tqvp_gera_gray_filter.sv
// tqvp_gera_gray_filter: glitch filter; stable_o is high while din_i has held for FILT_LEN consecutive samples.
module tqvp_gera_gray_filter #(
    parameter int GRAY_W   = 6,
    parameter int FILT_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [GRAY_W-1:0] din_i,
    output logic              stable_o,
    output logic [GRAY_W-1:0] sample_o
);
    logic [GRAY_W-1:0] sample_q;
    logic [3:0]        cnt_q, cnt_d;
    always_comb begin
        cnt_d    = (din_i != sample_q) ? 4'd1 : (cnt_q == 4'(FILT_LEN)) ? cnt_q : cnt_q + 4'd1;
        stable_o = en_i && cnt_d == 4'(FILT_LEN);
        sample_o = din_i;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_q <= '0;
            cnt_q    <= '0;
        end else begin
            sample_q <= din_i;
            cnt_q    <= en_i ? cnt_d : 4'd0;
        end
    end
endmodule

// File: rtl/tqvp_gera_gray_reader.sv
// tqvp_gera_gray_reader: filtered absolute Gray position reader with step, direction and error tracking.
// Define GRAY_READER_REV_EN to build the revolution counter; otherwise REV reads 0x00.
module tqvp_gera_gray_reader
    import tqvp_gera_gray_pkg::*;
#(
    parameter int GRAY_W   = 6,
    parameter int FILT_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);
    state_e            state_q, state_d;
    logic              en_q, en_d, inv_q, inv_d, chg_q, chg_d, err_q, err_d, dir_q, dir_d;
    logic [GRAY_W-1:0] pos_q, pos_d, raw_q, raw_d, sample, new_pos, delta;
    logic [7:0]        errcnt_q, errcnt_d, rev, pos8, status;
    logic              ctrl_wr, stat_wr, clr, stable, accept, track_acc;
    logic              step_up, step_dn, legal, illegal, up, valid;
    logic              unused_bits;

    assign unused_bits = ^{ui_in[7:GRAY_W], data_in[6:3]};
    assign ctrl_wr = data_write && address == ADDR_CTRL;
    assign stat_wr = data_write && address == ADDR_STATUS;
    assign clr     = ctrl_wr && data_in[CTRL_CLR];
    assign en_d    = ctrl_wr ? data_in[CTRL_EN] : en_q;
    assign inv_d   = ctrl_wr ? data_in[CTRL_INV] : inv_q;

    tqvp_gera_gray_filter #(.GRAY_W(GRAY_W), .FILT_LEN(FILT_LEN)) u_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (en_q),
        .din_i    (ui_in[GRAY_W-1:0]),
        .stable_o (stable),
        .sample_o (sample)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end
    // State follows the EN value being written so it always agrees with en_q.
    always_comb begin
        state_d = !en_d ? ST_IDLE :
                  clr ? ST_INIT :
                  (state_q == ST_IDLE) ? ST_INIT :
                  (state_q == ST_INIT && accept) ? ST_TRACK : state_q;
    end
    always_comb begin
        valid = state_q == ST_TRACK;
    end

    assign accept    = stable && state_q != ST_IDLE && (state_q == ST_INIT || sample != raw_q);
    assign track_acc = accept && state_q == ST_TRACK;
    assign new_pos   = GRAY_W'(gray2bin(8'(sample), GRAY_W));
    assign delta     = new_pos - pos_q;
    assign step_up   = delta == GRAY_W'(1);
    assign step_dn   = &delta;
    assign legal     = step_up || step_dn;
    assign illegal   = track_acc && !legal;
    assign up        = inv_q ? step_dn : step_up;

    always_comb begin
        pos_d    = accept ? new_pos : pos_q;
        raw_d    = accept ? sample : raw_q;
        chg_d    = clr ? 1'b0 : track_acc ? 1'b1 : (stat_wr && data_in[STAT_CHG]) ? 1'b0 : chg_q;
        err_d    = clr ? 1'b0 : illegal ? 1'b1 : (stat_wr && data_in[STAT_ERR]) ? 1'b0 : err_q;
        dir_d    = clr ? 1'b0 : (track_acc && legal) ? !up : dir_q;
        errcnt_d = clr ? 8'd0 : (illegal && errcnt_q != 8'hFF) ? errcnt_q + 8'd1 : errcnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q     <= 1'b0;
            inv_q    <= 1'b0;
            pos_q    <= '0;
            raw_q    <= '0;
            chg_q    <= 1'b0;
            err_q    <= 1'b0;
            dir_q    <= 1'b0;
            errcnt_q <= '0;
        end else begin
            en_q     <= en_d;
            inv_q    <= inv_d;
            pos_q    <= pos_d;
            raw_q    <= raw_d;
            chg_q    <= chg_d;
            err_q    <= err_d;
            dir_q    <= dir_d;
            errcnt_q <= errcnt_d;
        end
    end

`ifdef GRAY_READER_REV_EN
    logic [7:0] rev_q, rev_d;
    logic       wrap_up, wrap_dn;
    // Wraps count by raw code direction; INV only flips the sign.
    assign wrap_up = track_acc && step_up && &pos_q;
    assign wrap_dn = track_acc && step_dn && pos_q == '0;
    always_comb begin
        rev_d = clr ? 8'd0 :
                wrap_up ? (inv_q ? rev_q - 8'd1 : rev_q + 8'd1) :
                wrap_dn ? (inv_q ? rev_q + 8'd1 : rev_q - 8'd1) : rev_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) rev_q <= '0;
        else        rev_q <= rev_d;
    end
    assign rev = rev_q;
`else
    assign rev = 8'd0;
`endif

    assign pos8   = 8'(pos_q);
    assign uo_out = {err_q, chg_q, pos8[5:0]};
    always_comb begin
        status             = '0;
        status[STAT_VALID] = valid;
        status[STAT_CHG]   = chg_q;
        status[STAT_ERR]   = err_q;
        status[STAT_DIR]   = dir_q;
        case (address)
            ADDR_CTRL:   data_out = {6'd0, inv_q, en_q};
            ADDR_POS:    data_out = pos8;
            ADDR_RAW:    data_out = 8'(raw_q);
            ADDR_REV:    data_out = rev;
            ADDR_STATUS: data_out = status;
            ADDR_ERRCNT: data_out = errcnt_q;
            default:     data_out = 8'd0;
        endcase
    end
endmodule

// File: tb/tb_tqvp_gera_gray_reader.sv
// tb_tqvp_gera_gray_reader: vector table plus scoreboard checks of the Gray reader (GRAY_W=6, FILT_LEN=4).
module tb_tqvp_gera_gray_reader;
    logic       clk = 1'b0, rst_n = 1'b0, data_write = 1'b0;
    logic [7:0] ui_in = 8'h00, data_in = 8'h00, uo_out, data_out;
    logic [3:0] address = 4'h0;
    int         n_cmp = 0, n_bad = 0;
    logic [7:0] last_pos = 8'h00;

    typedef struct { logic [7:0] ui, pos, raw, st, ec, rev; } vec_t;
    typedef struct { string name; bit is_uo; logic [3:0] addr; logic [7:0] val; } exp_t;
    exp_t sb[$];
    vec_t vecs[9];

`ifdef GRAY_READER_REV_EN
    localparam logic [7:0] REV_P1 = 8'h01;
    localparam logic [7:0] REV_M1 = 8'hFF;
`else
    localparam logic [7:0] REV_P1 = 8'h00;
    localparam logic [7:0] REV_M1 = 8'h00;
`endif

    tqvp_gera_gray_reader #(.GRAY_W(6), .FILT_LEN(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ui_in      (ui_in),
        .uo_out     (uo_out),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    always #10 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        address = a;
        data_in = d;
        data_write = 1'b1;
        tick();
        data_write = 1'b0;
    endtask

    task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h, want %02h", n, act, exp);
        end
    endtask

    task automatic push(input string n, input bit u, input logic [3:0] a, input logic [7:0] v);
        exp_t e;
        e.name = n;
        e.is_uo = u;
        e.addr = a;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            address = e.addr;
            #1;
            chk(e.name, e.is_uo ? uo_out : data_out, e.val);
        end
    endtask

    task automatic expect_state(input string t, input logic [7:0] pos, raw, st, ec, rev);
        push({t, "_pos"}, 1'b0, 4'h1, pos);
        push({t, "_raw"}, 1'b0, 4'h2, raw);
        push({t, "_status"}, 1'b0, 4'h4, st);
        push({t, "_errcnt"}, 1'b0, 4'h5, ec);
        push({t, "_rev"}, 1'b0, 4'h3, rev);
        push({t, "_uo"}, 1'b1, 4'h0, {st[2], st[1], pos[5:0]});
    endtask

    task automatic apply_vec(input int i);
        vec_t v;
        v = vecs[i];
        ui_in = v.ui;
        tick(3);
        address = 4'h1;
        #1;
        chk($sformatf("v%0d_pos_early", i), data_out, last_pos);
        tick();
        expect_state($sformatf("v%0d", i), v.pos, v.raw, v.st, v.ec, v.rev);
        drain();
        last_pos = v.pos;
    endtask

    initial begin
        vecs[0] = '{8'h01, 8'h01, 8'h01, 8'h03, 8'h00, 8'h00};
        vecs[1] = '{8'h03, 8'h02, 8'h03, 8'h03, 8'h00, 8'h00};
        vecs[2] = '{8'h02, 8'h03, 8'h02, 8'h03, 8'h00, 8'h00};
        vecs[3] = '{8'h03, 8'h02, 8'h03, 8'h0B, 8'h00, 8'h00};
        vecs[4] = '{8'h05, 8'h06, 8'h05, 8'h0F, 8'h01, 8'h00};
        vecs[5] = '{8'h00, 8'h00, 8'h00, 8'h03, 8'h00, REV_P1};
        vecs[6] = '{8'h20, 8'h3F, 8'h20, 8'h0B, 8'h00, 8'h00};
        vecs[7] = '{8'h00, 8'h00, 8'h00, 8'h0B, 8'h00, REV_M1};
        vecs[8] = '{8'h20, 8'h3F, 8'h20, 8'h03, 8'h00, 8'h00};

        tick(3);
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < 8; a++) begin
            address = 4'(a);
            #1;
            chk($sformatf("reset_addr%0d", a), data_out, 8'h00);
        end
        chk("reset_uo", uo_out, 8'h00);

        wr(4'h0, 8'h01);
        tick(3);
        address = 4'h4;
        #1;
        chk("init_valid_early", data_out, 8'h00);
        tick();
        expect_state("init", 8'h00, 8'h00, 8'h01, 8'h00, 8'h00);
        drain();

        apply_vec(0);
        apply_vec(1);

        wr(4'h4, 8'h02);
        push("w1c_chg_status", 1'b0, 4'h4, 8'h01);
        drain();
        ui_in = 8'h07;
        tick(3);
        ui_in = 8'h03;
        tick(4);
        push("glitch_pos", 1'b0, 4'h1, 8'h02);
        push("glitch_status", 1'b0, 4'h4, 8'h01);
        push("glitch_uo", 1'b1, 4'h0, 8'h02);
        drain();
        wr(4'h6, 8'hFF);
        push("unmapped_read", 1'b0, 4'h6, 8'h00);
        push("unmapped_ctrl", 1'b0, 4'h0, 8'h01);
        drain();

        apply_vec(2);
        apply_vec(3);
        apply_vec(4);

        wr(4'h4, 8'h04);
        push("w1c_err_status", 1'b0, 4'h4, 8'h0B);
        push("w1c_err_errcnt", 1'b0, 4'h5, 8'h01);
        push("w1c_err_uo", 1'b1, 4'h0, 8'h46);
        drain();

        ui_in = 8'h20;
        wr(4'h0, 8'h81);
        tick(4);
        expect_state("clr", 8'h3F, 8'h20, 8'h01, 8'h00, 8'h00);
        push("clr_ctrl", 1'b0, 4'h0, 8'h01);
        drain();
        last_pos = 8'h3F;

        apply_vec(5);
        apply_vec(6);
        wr(4'h0, 8'h03);
        apply_vec(7);
        apply_vec(8);
        wr(4'h0, 8'h01);

        ui_in = 8'h01;
        tick(2);
        wr(4'h0, 8'h00);
        push("dis_status", 1'b0, 4'h4, 8'h02);
        push("dis_pos", 1'b0, 4'h1, 8'h3F);
        drain();
        tick(4);
        push("dis_hold_pos", 1'b0, 4'h1, 8'h3F);
        push("dis_hold_status", 1'b0, 4'h4, 8'h02);
        drain();
        wr(4'h0, 8'h01);
        tick(3);
        address = 4'h4;
        #1;
        chk("reen_valid_early", data_out, 8'h02);
        tick();
        expect_state("reen", 8'h01, 8'h01, 8'h03, 8'h00, 8'h00);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
